// File: rtl/bn_pkg.sv
// Shared definitions for the batch-statistics blocks: FSM state encoding and
// the fixed-point constants used for the range-based sigma estimate.
package bn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CALC  = 2'd2,
    ST_DONE  = 2'd3
  } bn_state_e;

  // Fractional bits of the sigma output (downstream divides by stan_dev >> 7).
  localparam int unsigned SIGMA_FRAC_BITS = 7;

  // Smallest sigma ever produced, so that the downstream stan_dev >> 7 is never 0.
  localparam int unsigned STD_MIN = 128;

endpackage

// File: rtl/range_scale.sv
// Combinational conversion of a batch range (max - min) into a sigma estimate:
// range * RANGE_SCALE (Q0.8) with one bit dropped, which leaves 7 fractional
// bits. The result is saturated to the positive signed maximum and clamped
// from below to STD_MIN.
module range_scale
  import bn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RANGE_SCALE = 89
) (
  input  logic        [DATA_WIDTH:0]   range_i,
  output logic signed [DATA_WIDTH-1:0] sigma_o
);

  localparam int unsigned PW = DATA_WIDTH + 1 + 8;
  localparam logic [7:0]    SCALE_C = 8'(RANGE_SCALE);
  localparam logic [PW-1:0] MAX_C   = PW'({(DATA_WIDTH-1){1'b1}});
  localparam logic [PW-1:0] MIN_C   = PW'(STD_MIN);

  logic [PW-1:0] prod_s;
  logic [PW-1:0] half_s;

  assign prod_s = PW'(range_i) * PW'(SCALE_C);
  assign half_s = prod_s >> 1;

  // Bound the scaled range into [STD_MIN, 2^(DATA_WIDTH-1)-1].
  always_comb begin
    if (half_s > MAX_C) begin
      sigma_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (half_s < MIN_C) begin
      sigma_o = DATA_WIDTH'(STD_MIN);
    end else begin
      sigma_o = DATA_WIDTH'(half_s);
    end
  end

endmodule

// File: rtl/range_stat.sv
// Mini-batch statistics: accumulates MINI_BATCH signed samples, then produces
// the floor mean and a range-based sigma estimate for the normalisation stage.
module range_stat
  import bn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MINI_BATCH  = 64,
  parameter int unsigned ADDR_WIDTH  = $clog2(MINI_BATCH),
  parameter int unsigned RANGE_SCALE = 89
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_in,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         x_valid_in,
  output logic                         x_ready_out,
  output logic signed [DATA_WIDTH-1:0] avg_out,
  output logic signed [DATA_WIDTH-1:0] stan_dev_out,
  output logic                         start_bn_tra_out
);

  localparam int unsigned SW = DATA_WIDTH + ADDR_WIDTH;

  bn_state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]       count_q, count_d;
  logic signed [SW-1:0]        sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic signed [DATA_WIDTH-1:0] avg_q, avg_d, std_q, std_d;
  logic                        start_bn_q, start_bn_d;

  logic                        x_ready_s, accept_s, last_s, clear_s, calc_s;
  logic [DATA_WIDTH:0]         range_s;
  logic signed [DATA_WIDTH-1:0] sigma_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; start_in only matters in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_in) state_d = ST_ACCUM; else state_d = ST_IDLE;
      ST_ACCUM: if (last_s)   state_d = ST_CALC;  else state_d = ST_ACCUM;
      ST_CALC:  state_d = ST_DONE;
      ST_DONE:  if (start_in) state_d = ST_ACCUM; else state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: handshake, batch-clear and compute strobes.
  always_comb begin
    x_ready_s = (state_q == ST_ACCUM);
    clear_s   = start_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    calc_s    = (state_q == ST_CALC);
    accept_s  = x_ready_s && x_valid_in;
    last_s    = accept_s && (count_q == ADDR_WIDTH'(MINI_BATCH - 1));
  end

  // Accumulator next state: clear on a new batch, update on each accepted sample.
  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    max_d   = max_q;
    min_d   = min_q;
    if (clear_s) begin
      count_d = '0;
      sum_d   = '0;
      max_d   = '0;
      min_d   = '0;
    end else if (accept_s) begin
      count_d = count_q + 1'b1;
      sum_d   = sum_q + $signed({{ADDR_WIDTH{x_in[DATA_WIDTH-1]}}, x_in});
      if (count_q == '0) begin
        max_d = x_in;
        min_d = x_in;
      end else begin
        if (x_in > max_q) max_d = x_in; else max_d = max_q;
        if (x_in < min_q) min_d = x_in; else min_d = min_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      min_q   <= min_d;
    end
  end

  // max >= min always holds, so the sign-extended difference is non-negative.
  assign range_s = {max_q[DATA_WIDTH-1], max_q} - {min_q[DATA_WIDTH-1], min_q};

  range_scale #(
    .DATA_WIDTH (DATA_WIDTH),
    .RANGE_SCALE(RANGE_SCALE)
  ) u_range_scale (
    .range_i(range_s),
    .sigma_o(sigma_s)
  );

  // Result next state: capture statistics in CALC; valid flag follows DONE
  // one edge later and drops on the edge that starts a new batch.
  always_comb begin
    avg_d = avg_q;
    std_d = std_q;
    if (calc_s) begin
      avg_d = DATA_WIDTH'(sum_q >>> ADDR_WIDTH);
      std_d = sigma_s;
    end else begin
      avg_d = avg_q;
    end
    start_bn_d = (state_q == ST_DONE) && !start_in;
  end

  // Result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q      <= '0;
      std_q      <= '0;
      start_bn_q <= 1'b0;
    end else begin
      avg_q      <= avg_d;
      std_q      <= std_d;
      start_bn_q <= start_bn_d;
    end
  end

  assign x_ready_out      = x_ready_s;
  assign avg_out          = avg_q;
  assign stan_dev_out     = std_q;
  assign start_bn_tra_out = start_bn_q;

endmodule

// File: tb/tb_range_stat.sv
// Self-checking bench for range_stat: table of batch patterns with expected
// statistics, a scoreboard queue filled when the last sample is driven and
// drained when the statistics-valid flag rises, plus a mid-batch reset sequence.
module tb_range_stat;

  localparam int DW = 16;
  localparam int MB = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start_in;
  logic signed [DW-1:0] x_in;
  logic                 x_valid_in;
  logic                 x_ready_out;
  logic signed [DW-1:0] avg_out;
  logic signed [DW-1:0] stan_dev_out;
  logic                 start_bn_tra_out;

  range_stat dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_in        (start_in),
    .x_in            (x_in),
    .x_valid_in      (x_valid_in),
    .x_ready_out     (x_ready_out),
    .avg_out         (avg_out),
    .stan_dev_out    (stan_dev_out),
    .start_bn_tra_out(start_bn_tra_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    bit gaps;
    bit start_mid;
    bit use_model;
    int exp_avg;
    int exp_std;
  } vec_t;

  typedef struct {
    int avg;
    int std;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rnd[MB];
  int   prev_avg = 0;
  int   prev_std = 0;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sample(input int pat, input int i);
    case (pat)
      0: return i;
      1: return 100;
      2: return (i % 2 == 0) ? -64 : 64;
      3: return (i < 3) ? -1 : 0;
      4: return (i == 0) ? -32768 : ((i == 1) ? 32767 : 0);
      5: return rnd[i];
      default: return 0;
    endcase
  endfunction

  // Independent reference: mean by floor division, sigma from range.
  function automatic exp_t model(input int pat);
    int s, mx, mn, p;
    exp_t e;
    s = 0; mx = sample(pat, 0); mn = mx;
    for (int i = 0; i < MB; i++) begin
      s += sample(pat, i);
      if (sample(pat, i) > mx) mx = sample(pat, i);
      if (sample(pat, i) < mn) mn = sample(pat, i);
    end
    e.avg = (s >= 0) ? s / MB : -((-s + MB - 1) / MB);
    p = ((mx - mn) * 89) / 2;
    if (p > 32767) p = 32767;
    if (p < 128) p = 128;
    e.std = p;
    return e;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    chk("ready_after_start", int'(x_ready_out), 1);
    chk("valid_drops_on_start", int'(start_bn_tra_out), 0);
    chk("avg_held", int'(avg_out), prev_avg);
    chk("std_held", int'(stan_dev_out), prev_std);
  endtask

  task automatic run_batch(input vec_t v);
    exp_t e;
    exp_t got;
    int   lat;
    pulse_start();
    for (int i = 0; i < MB; i++) begin
      if (v.gaps) begin
        repeat ($urandom_range(0, 2)) begin
          x_valid_in = 1'b0;
          x_in = DW'(12345);
          @(negedge clk);
        end
      end
      x_valid_in = 1'b1;
      x_in       = DW'(sample(v.pat, i));
      start_in   = v.start_mid && (i == 10);
      if (i == MB - 1) begin
        if (v.use_model) e = model(v.pat);
        else begin e.avg = v.exp_avg; e.std = v.exp_std; end
        sb_q.push_back(e);
      end
      @(negedge clk);
      start_in = 1'b0;
    end
    x_valid_in = 1'b0;
    chk("ready_low_in_calc", int'(x_ready_out), 0);
    lat = 0;
    while (!start_bn_tra_out && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("valid_latency", lat, 2);
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      got = sb_q.pop_front();
      chk($sformatf("avg_pat%0d", v.pat), int'(avg_out), got.avg);
      chk($sformatf("std_pat%0d", v.pat), int'(stan_dev_out), got.std);
      prev_avg = got.avg;
      prev_std = got.std;
    end
    @(negedge clk);
    chk("valid_holds_in_done", int'(start_bn_tra_out), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    rst_n = 1'b0; start_in = 1'b0; x_in = '0; x_valid_in = 1'b0;
    for (int i = 0; i < MB; i++) rnd[i] = int'($urandom_range(0, 4000)) - 2000;
    vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 31, 2803};
    vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 100, 128};
    vecs[2] = '{2, 1'b0, 1'b0, 1'b0, 0, 5696};
    vecs[3] = '{3, 1'b0, 1'b0, 1'b0, -1, 128};
    vecs[4] = '{4, 1'b0, 1'b0, 1'b0, -1, 32767};
    vecs[5] = '{0, 1'b1, 1'b1, 1'b0, 31, 2803};
    vecs[6] = '{5, 1'b1, 1'b0, 1'b1, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_avg", int'(avg_out), 0);
    chk("rst_std", int'(stan_dev_out), 0);
    chk("rst_valid", int'(start_bn_tra_out), 0);
    chk("rst_ready", int'(x_ready_out), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", int'(x_ready_out), 0);
    chk("idle_avg", int'(avg_out), 0);

    for (int k = 0; k < 7; k++) run_batch(vecs[k]);

    // Reset in the middle of a batch discards it.
    pulse_start();
    for (int i = 0; i <= 30; i++) begin
      x_valid_in = 1'b1; x_in = DW'(sample(2, i));
      @(negedge clk);
    end
    x_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_avg", int'(avg_out), 0);
    chk("midrst_std", int'(stan_dev_out), 0);
    chk("midrst_valid", int'(start_bn_tra_out), 0);
    chk("midrst_ready", int'(x_ready_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst_ready", int'(x_ready_out), 0);
    chk("postrst_std", int'(stan_dev_out), 0);
    prev_avg = 0; prev_std = 0;
    rv = vecs[0];
    run_batch(rv);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
